// File: rtl/clk_select_pkg.sv
// Shared types and default timing for the clock-select sequencer.
// Holds the FSM state encoding and the one-hot enable helper.
package clk_select_pkg;

  typedef enum logic [2:0] {
    STABLE    = 3'd0,
    DRAIN     = 3'd1,
    SWITCH    = 3'd2,
    ENABLE    = 3'd3,
    MMCM_RST  = 3'd4,
    WAIT_LOCK = 3'd5,
    ERROR     = 3'd6
  } state_e;

  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 65535;
  localparam int MAX_CLKS          = 16;

  // Callers truncate the result to their own source count.
  function automatic logic [MAX_CLKS-1:0] onehot16(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction

endpackage

// File: rtl/clk_select_seq_if.sv
// Switch-request handshake between a controller and the clock-select sequencer.
// master issues requests; slave (the sequencer) returns req_ready.
interface clk_select_seq_if #(
  parameter int SEL_W = 2
);
  logic             req_valid;
  logic             req_ready;
  logic [SEL_W-1:0] req_sel;
  logic             req_bypass;

  modport master (output req_valid, output req_sel, output req_bypass, input req_ready);
  modport slave  (input req_valid, input req_sel, input req_bypass, output req_ready);
endinterface

// File: rtl/cdc_sync_bit.sv
// Purpose: multi-flop synchroniser for one asynchronous level into clk.
// Latency: STAGES cycles from d to q.
// Backpressure: none; level signal only.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= STAGES'({sync_q, d});
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clk_select_seq.sv
// Purpose: glitch-free sequencer for NUM_CLKS sources plus MMCM reset/lock qualification; CLK_SELECT_SEQ_RELOCK_EN adds auto-relock.
// Latency: SETTLE_CYCLES+2 cycles per bypassed switch; MMCM path adds RST_CYCLES plus the lock wait.
// Backpressure: req_ready is low while a switch sequence is in flight.
module clk_select_seq
  import clk_select_pkg::*;
#(
  parameter int NUM_CLKS      = 4,
  parameter int SEL_W         = $clog2(NUM_CLKS),
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                clk,
  input  logic                resetn,
  clk_select_seq_if.slave     req,
  input  logic                mmcm_locked_async,
  output logic [NUM_CLKS-1:0] clk_ce,
  output logic [SEL_W-1:0]    clk_sel,
  output logic                pll_bypass,
  output logic                mmcm_reset,
  output logic                locked,
  output logic                busy,
  output logic                lock_err,
  output logic                sel_err
`ifdef CLK_SELECT_SEQ_RELOCK_EN
  ,
  output logic [7:0]          relock_count
`endif
);

  localparam int MAX_SR  = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CNT_MAX = (LOCK_TIMEOUT > MAX_SR) ? LOCK_TIMEOUT : MAX_SR;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  state_e           state_q, state_d;
  cnt_t             cnt_q;
  logic [SEL_W-1:0] lat_sel_q, clk_sel_q;
  logic             lat_bypass_q, pll_bypass_q;
  logic             lock_err_q, sel_err_q;
  logic             lock_sync;
  logic             accept, sel_oor, accept_ok;
`ifdef CLK_SELECT_SEQ_RELOCK_EN
  logic [7:0]       relock_q;
`endif

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (mmcm_locked_async),
    .q      (lock_sync)
  );

  // Out-of-range requests are consumed but never start a sequence.
  assign accept    = req.req_valid && req.req_ready;
  assign sel_oor   = 32'(req.req_sel) >= 32'(NUM_CLKS);
  assign accept_ok = accept && !sel_oor;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= STABLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STABLE: begin
        if (accept_ok) begin
          state_d = DRAIN;
        end
`ifdef CLK_SELECT_SEQ_RELOCK_EN
        else if (!pll_bypass_q && !lock_sync) begin
          state_d = MMCM_RST;
        end
`endif
      end
      DRAIN: begin
        if (cnt_q == cnt_t'(SETTLE_CYCLES - 1)) begin
          state_d = SWITCH;
        end
      end
      SWITCH:   state_d = ENABLE;
      ENABLE:   state_d = pll_bypass_q ? STABLE : MMCM_RST;
      MMCM_RST: begin
        if (cnt_q == cnt_t'(RST_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (lock_sync) begin
          state_d = STABLE;
        end else if (cnt_q >= cnt_t'(LOCK_TIMEOUT - 1)) begin
          state_d = ERROR;
        end
      end
      ERROR: begin
        if (accept_ok) begin
          state_d = DRAIN;
        end
      end
      default: state_d = STABLE;
    endcase
  end

  always_comb begin
    clk_ce         = NUM_CLKS'(onehot16(4'(clk_sel_q)));
    busy           = 1'b1;
    locked         = 1'b0;
    mmcm_reset     = 1'b0;
    req.req_ready  = 1'b0;
    case (state_q)
      STABLE: begin
        busy          = 1'b0;
        locked        = pll_bypass_q | lock_sync;
        req.req_ready = 1'b1;
      end
      DRAIN, SWITCH: clk_ce = '0;
      MMCM_RST:      mmcm_reset = 1'b1;
      ERROR: begin
        busy          = 1'b0;
        req.req_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Per-state counter restarts on every transition and saturates.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q        <= '0;
      lat_sel_q    <= '0;
      lat_bypass_q <= 1'b0;
      clk_sel_q    <= '0;
      pll_bypass_q <= 1'b1;
      lock_err_q   <= 1'b0;
      sel_err_q    <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (cnt_q != cnt_t'(CNT_MAX)) begin
        cnt_q <= cnt_q + cnt_t'(1);
      end
      sel_err_q <= accept && sel_oor;
      if (accept_ok) begin
        lat_sel_q    <= req.req_sel;
        lat_bypass_q <= req.req_bypass;
      end
      if (state_q == DRAIN && state_d == SWITCH) begin
        clk_sel_q    <= lat_sel_q;
        pll_bypass_q <= lat_bypass_q;
      end
      if (state_q == WAIT_LOCK) begin
        if (lock_sync) begin
          lock_err_q <= 1'b0;
        end else if (state_d == ERROR) begin
          lock_err_q <= 1'b1;
        end
      end
    end
  end

`ifdef CLK_SELECT_SEQ_RELOCK_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      relock_q <= '0;
    end else if (state_q == STABLE && state_d == MMCM_RST && relock_q != 8'hFF) begin
      relock_q <= relock_q + 8'd1;
    end
  end

  assign relock_count = relock_q;
`endif

  assign clk_sel    = clk_sel_q;
  assign pll_bypass = pll_bypass_q;
  assign lock_err   = lock_err_q;
  assign sel_err    = sel_err_q;

endmodule
